tx_word_arbiter: RTL and testbench
==================================

Name: tx_word_arbiter

Overview:
Sequencer and arbiter in front of the 40-bit UART word transmitter (32-bit word sent as 4 framed bytes: start bit, 8 data bits, stop bit each).
- Round-robin arbitration between NUM_REQ word sources.
- Latches the granted word and pulses the transmitter's load.
- Generates the per-bit baud strobe that advances the shifter, counts 40 bit periods, then confirms the transmitter's finish flag.
- Sits between the processor-side producers (core, debug dump) and the single serial TxD line.

Parameters:
NUM_REQ, 2, number of requesting sources (1..8)
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200)
BITS_PER_WORD, 40, bit periods per word, fixed by the 4x10-bit framing
GAP_BITS, 2, idle bit periods between words (used only with TX_GAP_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-source request; held with data until grant
req_data  in  32*NUM_REQ  word of source i at [32*i+31:32*i]
grant  out  NUM_REQ  one-hot, one-cycle pulse when source word is accepted
tx_data  out  32  latched word to transmitter
tx_start  out  1  transmitter load strobe
tx_tick  out  1  transmitter advance strobe; transmitter state updates only when high
tx_finish  in  1  transmitter idle/finished flag
busy  out  1  high in any state except IDLE
cur_src  out  max(1,$clog2(NUM_REQ))  index of source being sent
err  out  1  sticky: tx_finish low at word end

Behaviour:
- Reset (async, rst_n=0): state IDLE; grant=0, tx_data=0, tx_start=0, tx_tick=0, busy=0, cur_src=0, err=0; rr pointer=0; baud_cnt=0, bit_cnt=0. Reset mid-word aborts the word immediately, with no completion and no grant.
- All outputs are registered. States: IDLE, LOAD, SEND, DONE, GAP (GAP exists only with TX_GAP_EN).
- IDLE, any req high:
  - Select the first set req at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch req_data slice into tx_data; cur_src=index; go LOAD.
  - Requests arriving in the same cycle are resolved by the pointer only.
- LOAD (1 cycle):
  - grant[cur_src]=1, tx_start=1, tx_tick=1; transmitter loads on this edge.
  - rr pointer = cur_src+1, wrapping to 0 at NUM_REQ; baud_cnt=0, bit_cnt=0; go SEND.
- SEND:
  - baud_cnt counts 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1: tx_tick=1 for one cycle, baud_cnt wraps to 0, bit_cnt++.
  - When the tick makes bit_cnt reach BITS_PER_WORD, go DONE.
  - Latency req-grant: grant visible 1 cycle after req sampled in IDLE.
  - Word duration LOAD-to-DONE: 1 + 40*CLKS_PER_BIT cycles.
- DONE (1 cycle):
  - Sample tx_finish. If 0, set err; err is cleared only by reset.
  - Go GAP if TX_GAP_EN, else IDLE.
- Without TX_GAP_EN, back-to-back words: IDLE lasts exactly 1 cycle, then LOAD.
- tx_tick and tx_start are never high outside LOAD/SEND.
- req deassert or req_data change during SEND/DONE/GAP: no effect on the word in flight.
- NUM_REQ=1: pointer is constant 0 and cur_src is always 0.

Optional Feature:
Macro TX_GAP_EN.
- Defined: after DONE, enter GAP for GAP_BITS*CLKS_PER_BIT cycles with tx_tick=0 (line stays marking), then IDLE. busy remains high through GAP.
- Undefined: no GAP state, no gap counter; DONE goes straight to IDLE.

Decomposition:
- Shared package `uart_pkg`:
  - state enum (IDLE/LOAD/SEND/DONE/GAP)
  - BITS_PER_WORD=40
  - default CLKS_PER_BIT
  - width function for cur_src
- One sub-module, `baud_tick_gen`: counter with enable and sync clear, emitting a tick at CLKS_PER_BIT-1. Used for both SEND and GAP timing.
- Round-robin select stays inline.

Test Plan:
- CLKS_PER_BIT=4, req=01, data0=0x A5C3_0F81 -> grant=01 one cycle later; tx_start+tx_tick in the same cycle; then 40 ticks spaced 4 cycles; DONE with tx_finish=1; err=0; busy low after 162 cycles.
- req=11 held, pointer=0 -> order src0, src1, src0, src1; each grant one-hot; cur_src matches.
- Model tx_finish forced 0 at DONE -> err=1 and stays 1 across later good words until rst_n pulse.
- rst_n=0 at bit 17 of a word -> all outputs 0 asynchronously; after release, held req is re-granted from IDLE and no stale tick is emitted.
- TX_GAP_EN, GAP_BITS=2, CLKS_PER_BIT=4 -> 8 tick-free busy cycles between DONE and IDLE; next LOAD follows 1 cycle later.
- req toggled off and data changed mid-SEND -> tx_data unchanged, word completes, no extra grant.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the framed UART word path.
// Holds the sequencer state encoding, the fixed word framing length, the
// default bit period and the width helper for source indices.
package uart_pkg;

    // Sequencer states; ST_GAP is only entered when the inter-word gap is built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE,
        ST_GAP
    } tx_state_e;

    // 4 bytes x (start + 8 data + stop) bit periods per word.
    localparam int BITS_PER_WORD    = 40;

    // 50 MHz system clock at 115200 baud.
    localparam int DEF_CLKS_PER_BIT = 434;

    // Width of a source index; never narrower than one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled,
// flags the last count of each period, and clears synchronously.
// last_next tells the parent that the count it will see next cycle is the last
// one, so the parent can register its own strobe aligned with that cycle.
module baud_tick_gen
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic last_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_d;

    // Next count: clear wins over enable, wrap after the last count.
    always_comb begin
        baud_cnt_d = baud_cnt;
        if (clr) begin
            baud_cnt_d = '0;
        end else if (en) begin
            baud_cnt_d = (baud_cnt == LAST) ? '0 : baud_cnt + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt_d;
        end
    end

    assign tick      = en && !clr && (baud_cnt == LAST);
    assign last_next = (baud_cnt_d == LAST);

endmodule

// File: rtl/tx_word_arbiter.sv
// tx_word_arbiter: round-robin arbiter and bit sequencer in front of the 40-bit
// framed UART word transmitter. Optional idle gap between words: TX_GAP_EN.
//
// Handshake: a source raises req[i] with its word on req_data[32*i+:32] and
// holds both until grant[i] pulses. The word is captured on the edge that
// raises grant, so once grant[i] is seen the source may drop req or change its
// data without affecting the word in flight.
module tx_word_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int GAP_BITS     = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [32*NUM_REQ-1:0]           req_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [31:0]                     tx_data,
    output logic                            tx_start,
    output logic                            tx_tick,
    input  logic                            tx_finish,
    output logic                            busy,
    output logic [src_width(NUM_REQ)-1:0]   cur_src,
    output logic                            err
);

    localparam int SRC_W     = src_width(NUM_REQ);
    localparam int BIT_CNT_W = $clog2(max_int(BITS_PER_WORD, GAP_BITS) + 1);

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [SRC_W-1:0]     ptr_q;
    logic [SRC_W-1:0]     sel_idx;
    logic [NUM_REQ-1:0]   req_rot;
    int                   sel_off;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 baud_en;
    logic                 baud_clr;
    logic                 baud_tick;
    logic                 baud_last_next;
    logic                 word_end;

    // The same bit-period counter times the word and, when built in, the gap.
`ifdef TX_GAP_EN
    logic gap_end;
    assign baud_en  = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign gap_end  = baud_tick && (bit_cnt == BIT_CNT_W'(GAP_BITS - 1));
`else
    assign baud_en  = (state_q == ST_SEND);
`endif
    assign baud_clr = (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign word_end = baud_tick && (bit_cnt == BIT_CNT_W'(BITS_PER_WORD - 1));

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (baud_en),
        .clr       (baud_clr),
        .tick      (baud_tick),
        .last_next (baud_last_next)
    );

    // Round-robin pick: rotate requests so the pointer sits at bit 0, take the
    // lowest set bit, then rotate the offset back into a source index.
    always_comb begin
        req_rot = NUM_REQ'({req, req} >> ptr_q);
        sel_off = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_off = i;
            end
        end
        sel_idx = SRC_W'((int'(ptr_q) + sel_off) % NUM_REQ);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: if (word_end) state_d = ST_DONE;
`ifdef TX_GAP_EN
            ST_DONE: state_d = ST_GAP;
            ST_GAP:  if (gap_end) state_d = ST_IDLE;
`else
            ST_DONE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, pointer, bit counter and sticky error; outputs are
    // computed from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            tx_tick  <= 1'b0;
            busy     <= 1'b0;
            cur_src  <= '0;
            err      <= 1'b0;
            ptr_q    <= '0;
            bit_cnt  <= '0;
        end else begin
            grant    <= '0;
            tx_start <= 1'b0;
            tx_tick  <= (state_d == ST_SEND) && baud_last_next;
            busy     <= (state_d != ST_IDLE);

            if (state_q == ST_IDLE && state_d == ST_LOAD) begin
                tx_data  <= 32'(req_data >> (32 * int'(sel_idx)));
                cur_src  <= sel_idx;
                grant    <= NUM_REQ'(1) << sel_idx;
                tx_start <= 1'b1;
                tx_tick  <= 1'b1;
            end

            if (state_q == ST_LOAD) begin
                ptr_q <= (int'(cur_src) == NUM_REQ - 1) ? '0 : cur_src + 1'b1;
            end

            if (state_q == ST_LOAD || state_q == ST_DONE) begin
                bit_cnt <= '0;
            end else if (baud_tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state_q == ST_DONE && !tx_finish) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_word_arbiter.sv
// tb_tx_word_arbiter: directed-then-random bench for tx_word_arbiter with
// NUM_REQ=2 and a 4-clock bit period. Expected grants, words, tick spacing,
// busy length and the sticky error come from a small arbitration model.
module tb_tx_word_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int CPB       = 4;
    localparam int WORD_BITS = 40;
`ifdef TX_GAP_EN
    localparam int GAP_CYC   = 2 * CPB;
`else
    localparam int GAP_CYC   = 0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req;
    logic [31:0]             word_tbl [NUM_REQ];
    logic [32*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]      grant;
    logic [31:0]             tx_data;
    logic                    tx_start;
    logic                    tx_tick;
    logic                    tx_finish;
    logic                    busy;
    logic [0:0]              cur_src;
    logic                    err;

    int n_checks;
    int n_fail;
    int model_ptr;
    bit model_err;

    assign req_data = {word_tbl[1], word_tbl[0]};

    tx_word_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_tick   (tx_tick),
        .tx_finish (tx_finish),
        .busy      (busy),
        .cur_src   (cur_src),
        .err       (err)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: first requesting source at or after the pointer.
    function automatic int model_pick(input logic [NUM_REQ-1:0] r);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},    64'(grant),    64'd0);
        chk({tag, "_tx_data"},  64'(tx_data),  64'd0);
        chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_tx_tick"},  64'(tx_tick),  64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_cur_src"},  64'(cur_src),  64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
    endtask

    // One word, entered at a negedge in IDLE with req/data already set.
    // drop_at: <0 source keeps requesting with a fresh word after grant,
    //          0 source drops at grant, >0 source drops and scrambles data
    //          at that SEND cycle. abort_at > 0 pulses reset at that cycle.
    task automatic do_word(input bit fin, input int drop_at, input int abort_at);
        int src;
        logic [31:0] exp_word;
        int ticks, bad_tick, bad_ctl, bad_data, busy_len, gap_quiet;
        src      = model_pick(req);
        exp_word = word_tbl[src];
        @(posedge clk);
        @(negedge clk);
        chk("grant",     64'(grant),    64'(1) << src);
        chk("tx_start",  64'(tx_start), 64'd1);
        chk("load_tick", 64'(tx_tick),  64'd1);
        chk("cur_src",   64'(cur_src),  64'(src));
        chk("tx_data",   64'(tx_data),  64'(exp_word));
        model_ptr = (src + 1) % NUM_REQ;
        busy_len  = busy ? 1 : 0;
        tx_finish = 1'b0;
        if (drop_at == 0) req[src] = 1'b0;
        else if (drop_at < 0) word_tbl[src] = $urandom;
        ticks = 0; bad_tick = 0; bad_ctl = 0; bad_data = 0;
        for (int c = 1; c <= WORD_BITS * CPB; c++) begin
            @(negedge clk);
            if (tx_tick === 1'b1) begin
                ticks++;
                if (c % CPB != 0) bad_tick++;
            end else if (c % CPB == 0) begin
                bad_tick++;
            end
            if (grant !== '0 || tx_start !== 1'b0) bad_ctl++;
            if (busy === 1'b1) busy_len++;
            if (tx_data !== exp_word || int'(cur_src) != src) bad_data++;
            if (c == drop_at) begin
                req[src]      = 1'b0;
                word_tbl[src] = ~word_tbl[src];
            end
            if (c == abort_at) begin
                chk("abort_ticks", 64'(ticks), 64'(c / CPB));
                chk("abort_tick_pos", 64'(bad_tick), 64'd0);
                #2 rst_n = 1'b0;
                #1 chk_all_zero("async_rst");
                model_ptr = 0;
                model_err = 1'b0;
                tx_finish = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                chk("rst_release_tick", 64'(tx_tick), 64'd0);
                chk("rst_release_busy", 64'(busy),    64'd0);
                return;
            end
            if (c == WORD_BITS * CPB) tx_finish = fin;
        end
        @(negedge clk);
        chk("done_tick", 64'(tx_tick), 64'd0);
        if (busy === 1'b1) busy_len++;
        chk("word_ticks",   64'(ticks),    64'(WORD_BITS));
        chk("tick_spacing", 64'(bad_tick), 64'd0);
        chk("send_ctl",     64'(bad_ctl),  64'd0);
        chk("word_stable",  64'(bad_data), 64'd0);
        model_err = model_err | !fin;
`ifdef TX_GAP_EN
        gap_quiet = 0;
        for (int g = 0; g < GAP_CYC; g++) begin
            @(negedge clk);
            if (busy === 1'b1 && tx_tick === 1'b0 && tx_start === 1'b0) gap_quiet++;
            if (busy === 1'b1) busy_len++;
        end
        chk("gap_quiet", 64'(gap_quiet), 64'(GAP_CYC));
`else
        gap_quiet = 0;
`endif
        @(negedge clk);
        tx_finish = 1'b1;
        chk("idle_busy",  64'(busy),     64'd0);
        chk("idle_grant", 64'(grant),    64'd0);
        chk("idle_tick",  64'(tx_tick),  64'd0);
        chk("err",        64'(err),      64'(model_err));
        chk("busy_len",   64'(busy_len), 64'(2 + WORD_BITS * CPB + GAP_CYC + gap_quiet * 0));
    endtask

    // Directed steps followed by a randomized run.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        model_err = 1'b0;
        rst_n     = 1'b0;
        req       = '0;
        word_tbl[0] = '0;
        word_tbl[1] = '0;
        tx_finish = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single source, fixed word, source drops at grant.
        req = 2'b01;
        word_tbl[0] = 32'hA5C3_0F81;
        word_tbl[1] = $urandom;
        do_word(1'b1, 0, 0);
        @(negedge clk);
        chk("no_regrant",      64'(grant), 64'd0);
        chk("no_regrant_busy", 64'(busy),  64'd0);

        // Both sources held: grants must alternate.
        req = 2'b11;
        word_tbl[0] = $urandom;
        word_tbl[1] = $urandom;
        for (int w = 0; w < 4; w++) do_word(1'b1, -1, 0);

        // Transmitter not finished at word end: sticky error across good words.
        do_word(1'b0, -1, 0);
        do_word(1'b1, -1, 0);
        do_word(1'b1, -1, 0);

        // Source withdraws and changes its data mid-SEND.
        req = 2'b10;
        word_tbl[1] = $urandom;
        do_word(1'b1, 13 * CPB + 2, 0);
        @(negedge clk);
        chk("withdrawn_grant", 64'(grant), 64'd0);
        chk("withdrawn_busy",  64'(busy),  64'd0);

        // Reset during bit 17: word aborted, held requests re-arbitrated from 0.
        req = 2'b11;
        word_tbl[0] = $urandom;
        word_tbl[1] = $urandom;
        do_word(1'b1, -1, 17 * CPB + 1);
        do_word(1'b1, 0, 0);
        do_word(1'b1, 0, 0);

        // Random request patterns, words, finish flags and withdraw points.
        for (int w = 0; w < 6; w++) begin
            int mode;
            req = 2'($urandom_range(1, 3));
            word_tbl[0] = $urandom;
            word_tbl[1] = $urandom;
            mode = $urandom_range(0, 2);
            do_word($urandom_range(0, 3) != 0,
                    (mode == 0) ? -1 : (mode == 1) ? 0 : $urandom_range(1, WORD_BITS * CPB - 1),
                    0);
        end
        req = '0;
        @(negedge clk);
        chk("final_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
